// File: rtl/matrix_scan_controller_if.sv
// Frame-post channel between the status logic (producer) and the scan
// controller (consumer).
//   frame_data  : 21-bit image, column k rows at [7k+6:7k]
//   frame_valid : producer offers frame_data
//   frame_ready : consumer shadow buffer is empty
interface matrix_scan_controller_if;
  localparam int unsigned FRAME_W = 21;

  logic [FRAME_W-1:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/matrix_scan_controller.sv
// 3-column LED matrix scanner with blanking gaps and a double-buffered frame
// store; a posted image is committed only at a frame boundary or while idle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   enable       : run the scan; low blanks the matrix and parks in IDLE
//   frame_bus    : frame post channel (slave side)
//   col          : one-hot column select (col[2] first), 000 = all off
//   row          : row pattern for the lit column, 0 when dark
//   frame_done   : one-cycle pulse on the last lit cycle of each scan
module matrix_scan_controller #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  matrix_scan_controller_if.slave     frame_bus,
  output logic [2:0]                  col,
  output logic [6:0]                  row,
  output logic                        frame_done
);

  localparam int unsigned FRAME_W = 21;
  localparam int unsigned ROW_W   = 7;
  localparam int unsigned COL_W   = 3;
  localparam int unsigned CNT_W   = 16;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       IDX_FIRST  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [1:0]         index, index_next;
  logic [FRAME_W-1:0] active, active_next;
  logic [FRAME_W-1:0] shadow, shadow_next;
  logic               pending, pending_next;
  logic [COL_W-1:0]   col_d;
  logic [ROW_W-1:0]   row_d;
  logic               frame_done_d;
  logic               xfer;

  // Shadow is free whenever nothing is pending; forced low during reset.
  assign frame_bus.frame_ready = !pending && !reset;
  assign xfer = frame_bus.frame_valid && frame_bus.frame_ready;

  // State register: all sequential state including the registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      index      <= IDX_FIRST;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      index      <= index_next;
      active     <= active_next;
      shadow     <= shadow_next;
      pending    <= pending_next;
      col        <= col_d;
      row        <= row_d;
      frame_done <= frame_done_d;
    end
  end

  // Next-state logic: scan sequencing plus frame-buffer commit.
  always_comb begin
    state_next   = state;
    count_next   = count;
    index_next   = index;
    active_next  = active;
    shadow_next  = shadow;
    pending_next = pending;

    // Transfers only happen with pending clear, so they never collide with a swap.
    if (xfer) begin
      shadow_next  = frame_bus.frame_data;
      pending_next = 1'b1;
    end

    unique case (state)
      IDLE: begin
        index_next = IDX_FIRST;
        count_next = '0;
        if (pending) begin
          active_next  = shadow;
          pending_next = 1'b0;
        end
        if (enable) begin
          state_next = BLANK;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_next = IDLE;
          index_next = IDX_FIRST;
          count_next = '0;
        end else if (count == BLANK_LAST) begin
          state_next = SHOW;
          count_next = '0;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      SHOW: begin
        if (!enable) begin
          state_next = IDLE;
          index_next = IDX_FIRST;
          count_next = '0;
        end else if (count == DWELL_LAST) begin
          state_next = BLANK;
          count_next = '0;
          if (index != 2'd0) begin
            index_next = index - 2'd1;
          end else begin
            // Frame boundary: commit a posted image so no frame mixes images.
            index_next = IDX_FIRST;
            if (pending) begin
              active_next  = shadow;
              pending_next = 1'b0;
            end
          end
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        index_next = IDX_FIRST;
        count_next = '0;
      end
    endcase
  end

  // Output logic: decoded from next-state values so col/row/frame_done
  // register in lockstep with the state they describe.
  always_comb begin
    col_d        = '0;
    row_d        = '0;
    frame_done_d = 1'b0;
    if (state_next == SHOW) begin
      unique case (index_next)
        2'd2: begin
          col_d = 3'b100;
          row_d = active_next[20:14];
        end
        2'd1: begin
          col_d = 3'b010;
          row_d = active_next[13:7];
        end
        default: begin
          col_d = 3'b001;
          row_d = active_next[6:0];
        end
      endcase
      frame_done_d = (index_next == 2'd0) && (count_next == DWELL_LAST);
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Directed bench for matrix_scan_controller with D = 4, B = 2 (18-cycle frame).
module tb_matrix_scan_controller;

  localparam int unsigned D = 4;
  localparam int unsigned B = 2;
  localparam int unsigned SEG = D + B;
  localparam int unsigned FRAME = 3 * SEG;

  localparam logic [20:0] IMG1 = 21'h1FC07F;
  localparam logic [20:0] IMG2 = 21'h000001;
  localparam logic [20:0] IMG3 = {7'h55, 7'h2A, 7'h33};
  localparam logic [20:0] IMG4 = 21'h1FFFFF;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [2:0] col;
  logic [6:0] row;
  logic       frame_done;

  int n_vec;
  int n_err;
  int pos;

  matrix_scan_controller_if bus ();

  matrix_scan_controller #(
    .DWELL_CYCLES (D),
    .BLANK_CYCLES (B)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .frame_bus  (bus),
    .col        (col),
    .row        (row),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs n cycles of a running scan, checking col/row/frame_done against
  // the cycle position inside an 18-cycle frame and the expected image.
  task automatic scan(input int n, input logic [20:0] img);
    int seg;
    int w;
    logic [2:0] ecol;
    logic [6:0] erow;
    logic [20:0] sh;
    for (int i = 0; i < n; i++) begin
      tick();
      seg = pos / SEG;
      w   = pos % SEG;
      if (w < B) begin
        ecol = 3'b000;
        erow = 7'h00;
      end else begin
        ecol = 3'b100 >> seg;
        sh   = img >> (7 * (2 - seg));
        erow = sh[6:0];
      end
      check_eq($sformatf("col[p%0d]", pos), 32'(col), 32'(ecol));
      check_eq($sformatf("row[p%0d]", pos), 32'(row), 32'(erow));
      check_eq($sformatf("done[p%0d]", pos), 32'(frame_done), 32'(pos == FRAME - 1));
      pos = (pos + 1) % FRAME;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    pos   = 0;
    reset = 1'b1;
    enable = 1'b1;
    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;

    // Reset with enable high: everything dark, ready low.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_col", 32'(col), 32'h0);
      check_eq("rst_row", 32'(row), 32'h0);
      check_eq("rst_done", 32'(frame_done), 32'h0);
      check_eq("rst_ready", 32'(bus.frame_ready), 32'h0);
    end
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    check_eq("ready_after_rst", 32'(bus.frame_ready), 32'h1);
    check_eq("idle_col", 32'(col), 32'h0);

    // Load IMG1 while idle; it commits on the following edge.
    bus.frame_data  = IMG1;
    bus.frame_valid = 1'b1;
    tick();
    check_eq("idle_xfer_ready", 32'(bus.frame_ready), 32'h0);
    bus.frame_valid = 1'b0;
    tick();
    check_eq("idle_commit_ready", 32'(bus.frame_ready), 32'h1);

    // Basic scan, frame 1.
    enable = 1'b1;
    pos = 0;
    scan(FRAME, IMG1);

    // Frame 2: post IMG2 while col = 010, then hold a second image under back-pressure.
    scan(9, IMG1);
    bus.frame_data  = IMG2;
    bus.frame_valid = 1'b1;
    scan(1, IMG1);
    check_eq("mid_ready_drop", 32'(bus.frame_ready), 32'h0);
    bus.frame_data = IMG3;
    scan(FRAME - 10, IMG1);
    check_eq("bp_ready_at_done", 32'(bus.frame_ready), 32'h0);

    // Frame 3: shows IMG2; IMG3 accepted on the cycle after the swap.
    scan(1, IMG2);
    check_eq("ready_after_swap", 32'(bus.frame_ready), 32'h1);
    scan(1, IMG2);
    check_eq("bp_accept", 32'(bus.frame_ready), 32'h0);
    bus.frame_valid = 1'b0;
    scan(FRAME - 2, IMG2);

    // Frame 4: IMG3 displayed one frame later.
    scan(FRAME, IMG3);
    check_eq("ready_frame4_end", 32'(bus.frame_ready), 32'h1);

    // Enable drop during col = 010.
    scan(9, IMG3);
    enable = 1'b0;
    tick();
    check_eq("drop_col", 32'(col), 32'h0);
    check_eq("drop_row", 32'(row), 32'h0);
    tick();
    check_eq("drop_col_idle", 32'(col), 32'h0);
    enable = 1'b1;
    pos = 0;
    scan(SEG, IMG3);

    // Post IMG4, then reset mid-SHOW while it is pending.
    bus.frame_data  = IMG4;
    bus.frame_valid = 1'b1;
    scan(1, IMG3);
    bus.frame_valid = 1'b0;
    check_eq("pend_ready", 32'(bus.frame_ready), 32'h0);
    scan(3, IMG3);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_col", 32'(col), 32'h0);
    check_eq("mid_rst_row", 32'(row), 32'h0);
    check_eq("mid_rst_done", 32'(frame_done), 32'h0);
    check_eq("mid_rst_ready", 32'(bus.frame_ready), 32'h0);
    reset = 1'b0;
    pos = 0;
    scan(1, 21'h0);
    check_eq("post_rst_ready", 32'(bus.frame_ready), 32'h1);
    scan(FRAME - 1, 21'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
